// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pll_lock_supervisor                                        |
// | Description : Reset/lock supervisor for an rPLL on the board clock.      |
// |               Pulses the PLL reset after power-up. Synchronises and      |
// |               qualifies the PLL lock. Holds downstream logic in reset    |
// |               until lock is stable. Re-resets the PLL on lock loss or    |
// |               lock timeout. Latches a fault when the retry budget is     |
// |               exhausted.                                                 |
// | Build macro : PLL_RETRY_CNT_EN - when defined, exposes the retry counter |
// |               on port retry_cnt. FSM behaviour is identical either way.  |
// | Ports       : sys_clk   in   board clock (also PLL clkin)                |
// |               sys_rst_n in   asynchronous active-low reset              |
// |               pll_lock  in   PLL lock, asynchronous to sys_clk          |
// |               pll_reset out  active-high PLL reset                       |
// |               pll_ready out  high only while locked and stable (RUN)     |
// |               rst_out_n out  active-low downstream reset (= pll_ready)   |
// |               retry_cnt out  timeout retries so far (optional port)      |
// |               fault     out  sticky, retry budget exhausted              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 500000,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned MAX_RETRY        = 7
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       pll_ready,
  output logic       rst_out_n,
`ifdef PLL_RETRY_CNT_EN
  output logic [2:0] retry_cnt,
`endif
  output logic       fault
);

  // The shared counter only has to reach the largest terminal value minus one.
  localparam int unsigned c_max_ab  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ?
                                      RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int unsigned c_max_cnt = (c_max_ab > LOCK_STABLE_CYC) ?
                                      c_max_ab : LOCK_STABLE_CYC;
  localparam int          CNT_W     = ($clog2(c_max_cnt) < 1) ? 1 : $clog2(c_max_cnt);

  localparam logic [CNT_W-1:0] c_rst_last     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [2:0]       c_max_retry    = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic             sync1_q;
  logic             lock_s_q;
  logic             pll_reset_q, pll_reset_d;
  logic             pll_ready_q, pll_ready_d;
  logic             rst_out_n_q;
  logic             fault_q, fault_d;

  logic [CNT_W-1:0] w_cnt_inc;
  logic [2:0]       w_retry_inc;

  // Saturating increments: neither counter ever wraps.
  assign w_cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign w_retry_inc = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;

  // Two-flop synchroniser for the asynchronous lock input.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_RST_PLL;
      cnt_q       <= '0;
      retry_q     <= 3'd0;
      pll_reset_q <= 1'b1;
      pll_ready_q <= 1'b0;
      rst_out_n_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      pll_ready_q <= pll_ready_d;
      rst_out_n_q <= pll_ready_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state logic. Outputs are decoded from the next state so that they
  // change on the same edge as the state itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = w_cnt_inc;
    retry_d = retry_q;

    case (state_q)
      ST_RST_PLL: begin
        if (cnt_q == c_rst_last) begin
          state_d = ST_WAIT_LOCK;
        end
      end

      ST_WAIT_LOCK: begin
        // A lock arriving on the timeout cycle takes priority over the retry.
        if (lock_s_q) begin
          state_d = ST_STABLE;
        end else if (cnt_q == c_timeout_last) begin
          retry_d = w_retry_inc;
          state_d = (w_retry_inc == c_max_retry) ? ST_FAULT : ST_RST_PLL;
        end
      end

      ST_STABLE: begin
        // Any drop of the lock restarts qualification with a fresh timeout;
        // this is not a failed attempt, so retry is left alone.
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == c_stable_last) begin
          state_d = ST_RUN;
          retry_d = 3'd0;
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s_q) begin
          state_d = ST_RST_PLL;
        end
      end

      ST_FAULT: begin
        cnt_d   = cnt_q;
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_RST_PLL;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    pll_reset_d = (state_d == ST_RST_PLL) || (state_d == ST_FAULT);
    pll_ready_d = (state_d == ST_RUN);
    fault_d     = fault_q || (state_d == ST_FAULT);
  end

  assign pll_reset = pll_reset_q;
  assign pll_ready = pll_ready_q;
  assign rst_out_n = rst_out_n_q;
  assign fault     = fault_q;
`ifdef PLL_RETRY_CNT_EN
  assign retry_cnt = retry_q;
`endif

endmodule
`default_nettype wire
